// File: rtl/falu_cvt_fp2fp_sched.sv
// ---------------------------------------------------------------------------
// falu_cvt_fp2fp_sched
//   Scheduler for the single shared SP<->DP precision converter in the FALU.
//   Two issue lanes are arbitrated round-robin. The winner is registered into
//   an issue stage (S1), converted combinationally, and written into a small
//   output FIFO that drains toward writeback with valid/ready.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   FLUSH           drop every in-flight and buffered uop
//   FRM             dynamic rounding mode, used when the uop rm is 3'b111
//   Lx_VALID/READY  lane handshake (x = 0, 1)
//   Lx_DATA         source operand (SP in [31:0] when converting to DP)
//   Lx_RM           instruction rm field
//   Lx_IS_DOUBLE    1: SP->DP, 0: DP->SP
//   Lx_TAG          uop tag
//   OUT_VALID/READY result handshake at the FIFO head
//   OUT_DATA        result, DP->SP results NaN-boxed
//   OUT_FFLAGS      {NV,DZ,OF,UF,NX}
//   OUT_ILLEGAL     resolved rm was reserved; data and flags forced to zero
//   OUT_TAG         tag of the FIFO head
//   BUSY            S1 occupied or FIFO non-empty
// ---------------------------------------------------------------------------
module falu_cvt_fp2fp_sched #(
    parameter int TAG_W = 6,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic [2:0]       FRM,
    input  logic             L0_VALID,
    output logic             L0_READY,
    input  logic [63:0]      L0_DATA,
    input  logic [2:0]       L0_RM,
    input  logic             L0_IS_DOUBLE,
    input  logic [TAG_W-1:0] L0_TAG,
    input  logic             L1_VALID,
    output logic             L1_READY,
    input  logic [63:0]      L1_DATA,
    input  logic [2:0]       L1_RM,
    input  logic             L1_IS_DOUBLE,
    input  logic [TAG_W-1:0] L1_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [63:0]      OUT_DATA,
    output logic [4:0]       OUT_FFLAGS,
    output logic             OUT_ILLEGAL,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             BUSY
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic             s1_valid;
    logic [63:0]      s1_data;
    logic             s1_is_double;
    logic [2:0]       s1_rm;
    logic             s1_illegal;
    logic [TAG_W-1:0] s1_tag;

    logic [CW-1:0]    count;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             rr_ptr;

    logic [63:0]      mem_data    [DEPTH];
    logic [4:0]       mem_fflags  [DEPTH];
    logic             mem_illegal [DEPTH];
    logic [TAG_W-1:0] mem_tag     [DEPTH];

    logic [CW:0]      used;
    logic             has_space;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [2:0]       lane_rm;
    logic [2:0]       rm_res;
    logic             push;
    logic             pop;

    logic [63:0]      cvt_res;
    logic             cvt_nv;
    logic             cvt_of;
    logic             cvt_uf;
    logic             cvt_nx;

    // Credit counts the S1 slot as already spoken for; OUT_READY is
    // deliberately not folded in so READY never depends on writeback.
    assign used       = {1'b0, count} + {{CW{1'b0}}, s1_valid};
    assign has_space  = used < (CW+1)'(DEPTH);
    assign can_accept = has_space && !FLUSH && !RST;

    assign grant0 = can_accept && L0_VALID && (!L1_VALID || !rr_ptr);
    assign grant1 = can_accept && L1_VALID && (!L0_VALID ||  rr_ptr);
    assign accept = grant0 || grant1;

    assign L0_READY = grant0;
    assign L1_READY = grant1;

    assign lane_rm = grant1 ? L1_RM : L0_RM;
    assign rm_res  = (lane_rm == 3'b111) ? FRM : lane_rm;

    assign OUT_VALID = (count != '0);
    assign push      = s1_valid && !FLUSH && !RST;
    assign pop       = OUT_VALID && OUT_READY && !FLUSH && !RST;
    assign BUSY      = s1_valid || OUT_VALID;

    assign OUT_DATA    = OUT_VALID ? mem_data[rd_ptr]    : '0;
    assign OUT_FFLAGS  = OUT_VALID ? mem_fflags[rd_ptr]  : '0;
    assign OUT_ILLEGAL = OUT_VALID ? mem_illegal[rd_ptr] : 1'b0;
    assign OUT_TAG     = OUT_VALID ? mem_tag[rd_ptr]     : '0;

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            s1_valid <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            rr_ptr   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) rr_ptr <= ~grant1;
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            s1_data      <= grant1 ? L1_DATA      : L0_DATA;
            s1_is_double <= grant1 ? L1_IS_DOUBLE : L0_IS_DOUBLE;
            s1_tag       <= grant1 ? L1_TAG       : L0_TAG;
            s1_rm        <= rm_res;
            s1_illegal   <= (rm_res >= 3'b101);
        end
        if (push) begin
            mem_data[wr_ptr]    <= s1_illegal ? 64'h0 : cvt_res;
            mem_fflags[wr_ptr]  <= s1_illegal ? 5'h0 : {cvt_nv, 1'b0, cvt_of, cvt_uf, cvt_nx};
            mem_illegal[wr_ptr] <= s1_illegal;
            mem_tag[wr_ptr]     <= s1_tag;
        end
    end

    falu_fp2fp_cvt u_cvt (
        .src       (s1_data),
        .is_double (s1_is_double),
        .rm        (s1_rm),
        .res       (cvt_res),
        .nv        (cvt_nv),
        .of        (cvt_of),
        .uf        (cvt_uf),
        .nx        (cvt_nx)
    );

endmodule

// ---------------------------------------------------------------------------
// falu_fp2fp_cvt
//   Combinational SP<->DP converter.
//   src        operand (SP in [31:0] when is_double=1)
//   is_double  1: SP->DP, 0: DP->SP (result NaN-boxed)
//   rm         resolved, legal rounding mode
//   res        result; nv/of/uf/nx exception flags
// ---------------------------------------------------------------------------
module falu_fp2fp_cvt (
    input  logic [63:0] src,
    input  logic        is_double,
    input  logic [2:0]  rm,
    output logic [63:0] res,
    output logic        nv,
    output logic        of,
    output logic        uf,
    output logic        nx
);

    function automatic logic rnd_inc(input logic [2:0] mode, input logic s,
                                     input logic lsb, input logic g, input logic st);
        case (mode)
            3'b000:  rnd_inc = g && (st || lsb);
            3'b010:  rnd_inc = s && (g || st);
            3'b011:  rnd_inc = !s && (g || st);
            3'b100:  rnd_inc = g;
            default: rnd_inc = 1'b0;
        endcase
    endfunction

    logic               sp_s;
    logic [7:0]         sp_e;
    logic [22:0]        sp_m;
    logic [4:0]         sp_lz;
    logic               sp_found;
    logic [22:0]        sp_norm;

    logic               dp_s;
    logic [10:0]        dp_e;
    logic [51:0]        dp_m;
    logic [52:0]        sig;
    logic signed [12:0] exp_sp;
    logic signed [12:0] shd;
    logic               norm;
    logic [4:0]         sh;
    logic [78:0]        shifted;
    logic [23:0]        kept;
    logic               g;
    logic               st;
    logic               inexact;
    logic [24:0]        rnd;
    logic               ovf;
    logic [7:0]         ef;
    logic               uf_exempt;
    logic               to_max;

    assign sp_s = src[31];
    assign sp_e = src[30:23];
    assign sp_m = src[22:0];
    assign dp_s = src[63];
    assign dp_e = src[62:52];
    assign dp_m = src[51:0];

    // SP subnormals become DP normals: count leading zeros, then drop the
    // leading one out of the fraction field.
    always_comb begin
        sp_lz    = '0;
        sp_found = 1'b0;
        for (int i = 22; i >= 0; i--) begin
            if (!sp_found) begin
                if (sp_m[i]) sp_found = 1'b1;
                else         sp_lz    = sp_lz + 5'd1;
            end
        end
        sp_norm = sp_m << (sp_lz + 5'd1);
    end

    // DP->SP: one shifter covers normal (sh=0) and subnormal targets. The
    // 26 zero pad bits absorb the maximum shift, so nothing nonzero is lost.
    assign sig     = {dp_e != 11'h0, dp_m};
    assign exp_sp  = $signed({2'b00, dp_e}) - 13'sd896;
    assign norm    = exp_sp > 13'sd0;
    assign shd     = 13'sd1 - exp_sp;
    assign sh      = norm ? 5'd0 : ((shd > 13'sd26) ? 5'd26 : shd[4:0]);
    assign shifted = {sig, 26'h0} >> sh;
    assign kept    = shifted[78:55];
    assign g       = shifted[54];
    assign st      = |shifted[53:0];
    assign inexact = g || st;
    assign rnd     = {1'b0, kept} + {24'h0, rnd_inc(rm, dp_s, kept[0], g, st)};
    assign ovf     = norm && ((exp_sp >= 13'sd255) || ((exp_sp == 13'sd254) && rnd[24]));
    assign ef      = norm ? (exp_sp[7:0] + {7'h0, rnd[24]}) : {7'h0, rnd[23]};

    // Tininess is judged after rounding: a value just below the normal range
    // that rounds up to 2^-126 at full precision does not underflow.
    assign uf_exempt = (exp_sp == 13'sd0) && (&sig[52:29]) &&
                       rnd_inc(rm, dp_s, 1'b1, sig[28], |sig[27:0]);

    assign to_max = (rm == 3'b001) || ((rm == 3'b010) && !dp_s) || ((rm == 3'b011) && dp_s);

    always_comb begin
        res = '0;
        nv  = 1'b0;
        of  = 1'b0;
        uf  = 1'b0;
        nx  = 1'b0;
        if (is_double) begin
            if (sp_e == 8'hFF) begin
                if (sp_m == '0) begin
                    res = {sp_s, 11'h7FF, 52'h0};
                end else begin
                    res = 64'h7FF8_0000_0000_0000;
                    nv  = !sp_m[22];
                end
            end else if (sp_e == 8'h00) begin
                if (sp_m == '0) res = {sp_s, 63'h0};
                else            res = {sp_s, 11'd896 - {6'h0, sp_lz}, sp_norm, 29'h0};
            end else begin
                res = {sp_s, {3'h0, sp_e} + 11'd896, sp_m, 29'h0};
            end
        end else begin
            if (dp_e == 11'h7FF) begin
                if (dp_m == '0) begin
                    res = {32'hFFFF_FFFF, dp_s, 8'hFF, 23'h0};
                end else begin
                    res = 64'hFFFF_FFFF_7FC0_0000;
                    nv  = !dp_m[51];
                end
            end else if (ovf) begin
                of  = 1'b1;
                nx  = 1'b1;
                res = to_max ? {32'hFFFF_FFFF, dp_s, 8'hFE, 23'h7F_FFFF}
                             : {32'hFFFF_FFFF, dp_s, 8'hFF, 23'h0};
            end else begin
                res = {32'hFFFF_FFFF, dp_s, ef, rnd[22:0]};
                nx  = inexact;
                uf  = !norm && inexact && !uf_exempt;
            end
        end
    end

endmodule

// File: tb/tb_falu_cvt_fp2fp_sched.sv
module tb_falu_cvt_fp2fp_sched;

    localparam int TAG_W = 6;
    localparam int DEPTH = 2;

    logic             CLK;
    logic             RST;
    logic             FLUSH;
    logic [2:0]       FRM;
    logic             L0_VALID, L1_VALID;
    logic             L0_READY, L1_READY;
    logic [63:0]      L0_DATA, L1_DATA;
    logic [2:0]       L0_RM, L1_RM;
    logic             L0_IS_DOUBLE, L1_IS_DOUBLE;
    logic [TAG_W-1:0] L0_TAG, L1_TAG;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [63:0]      OUT_DATA;
    logic [4:0]       OUT_FFLAGS;
    logic             OUT_ILLEGAL;
    logic [TAG_W-1:0] OUT_TAG;
    logic             BUSY;

    int n_checks = 0;
    int n_errors = 0;

    int               glane[$];
    logic [TAG_W-1:0] gtag[$];
    logic [TAG_W-1:0] otag[$];
    int               n0, n1;

    falu_cvt_fp2fp_sched #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .FRM(FRM),
        .L0_VALID(L0_VALID), .L0_READY(L0_READY), .L0_DATA(L0_DATA),
        .L0_RM(L0_RM), .L0_IS_DOUBLE(L0_IS_DOUBLE), .L0_TAG(L0_TAG),
        .L1_VALID(L1_VALID), .L1_READY(L1_READY), .L1_DATA(L1_DATA),
        .L1_RM(L1_RM), .L1_IS_DOUBLE(L1_IS_DOUBLE), .L1_TAG(L1_TAG),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_FFLAGS(OUT_FFLAGS), .OUT_ILLEGAL(OUT_ILLEGAL), .OUT_TAG(OUT_TAG),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Starts and ends at posedge+1 with an empty pipeline and OUT_READY=1.
    task automatic issue_one(input int lane, input logic [63:0] d, input logic [2:0] rm,
                             input logic isd, input logic [TAG_W-1:0] tag,
                             input logic [63:0] ed, input logic [4:0] ef,
                             input logic eill, input string name);
        if (lane == 0) begin
            L0_VALID = 1'b1; L0_DATA = d; L0_RM = rm; L0_IS_DOUBLE = isd; L0_TAG = tag;
        end else begin
            L1_VALID = 1'b1; L1_DATA = d; L1_RM = rm; L1_IS_DOUBLE = isd; L1_TAG = tag;
        end
        #1;
        chk({name, "_ready"}, (lane == 0) ? L0_READY : L1_READY, 64'd1);
        @(posedge CLK); #1;
        L0_VALID = 1'b0;
        L1_VALID = 1'b0;
        chk({name, "_lat"}, OUT_VALID, 64'd0);
        @(posedge CLK); #1;
        chk({name, "_valid"}, OUT_VALID, 64'd1);
        chk({name, "_data"}, OUT_DATA, ed);
        chk({name, "_fflags"}, OUT_FFLAGS, ef);
        chk({name, "_illegal"}, OUT_ILLEGAL, eill);
        chk({name, "_tag"}, OUT_TAG, tag);
        @(posedge CLK); #1;
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; FRM = 3'b000; OUT_READY = 1'b0;
        L0_VALID = 1'b1; L0_DATA = '0; L0_RM = '0; L0_IS_DOUBLE = 1'b0; L0_TAG = '0;
        L1_VALID = 1'b0; L1_DATA = '0; L1_RM = '0; L1_IS_DOUBLE = 1'b0; L1_TAG = '0;

        // Reset
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_l0_ready", L0_READY, 64'd0);
        chk("rst_out_valid", OUT_VALID, 64'd0);
        chk("rst_busy", BUSY, 64'd0);
        chk("rst_out_data", OUT_DATA, 64'd0);
        chk("rst_out_tag", OUT_TAG, 64'd0);
        RST = 1'b0;
        L0_VALID = 1'b0;
        OUT_READY = 1'b1;

        // Directed conversions
        issue_one(0, 64'h0000_0000_3F80_0000, 3'b000, 1'b1, 6'd5,
                  64'h3FF0_0000_0000_0000, 5'b00000, 1'b0, "sp2dp_one");
        issue_one(0, 64'h0000_0000_7F80_0001, 3'b000, 1'b1, 6'd6,
                  64'h7FF8_0000_0000_0000, 5'b10000, 1'b0, "sp2dp_snan");
        issue_one(0, 64'h0000_0000_0000_0001, 3'b000, 1'b1, 6'd7,
                  64'h36A0_0000_0000_0000, 5'b00000, 1'b0, "sp2dp_subnormal");
        issue_one(1, 64'h3FF0_0000_0000_0000, 3'b000, 1'b0, 6'd8,
                  64'hFFFF_FFFF_3F80_0000, 5'b00000, 1'b0, "dp2sp_one");
        issue_one(1, 64'h7FF0_0000_0000_0001, 3'b000, 1'b0, 6'd9,
                  64'hFFFF_FFFF_7FC0_0000, 5'b10000, 1'b0, "dp2sp_snan");
        issue_one(1, 64'h3FF0_0000_1000_0000, 3'b011, 1'b0, 6'd10,
                  64'hFFFF_FFFF_3F80_0001, 5'b00001, 1'b0, "dp2sp_rup");
        FRM = 3'b001;
        issue_one(1, 64'h3FF0_0000_1000_0000, 3'b111, 1'b0, 6'd11,
                  64'hFFFF_FFFF_3F80_0000, 5'b00001, 1'b0, "dp2sp_dyn_rtz");
        issue_one(1, 64'h3FF0_0000_1000_0000, 3'b101, 1'b0, 6'd12,
                  64'h0, 5'b00000, 1'b1, "illegal_rm");
        issue_one(0, 64'h47F0_0000_0000_0000, 3'b001, 1'b0, 6'd13,
                  64'hFFFF_FFFF_7F7F_FFFF, 5'b00101, 1'b0, "dp2sp_ovf_rtz");
        issue_one(0, 64'h3690_0000_0000_0000, 3'b000, 1'b0, 6'd14,
                  64'hFFFF_FFFF_0000_0000, 5'b00011, 1'b0, "dp2sp_uf_tie");
        issue_one(1, 64'h36A0_0000_0000_0000, 3'b000, 1'b0, 6'd15,
                  64'hFFFF_FFFF_0000_0001, 5'b00000, 1'b0, "dp2sp_min_subn");

        // Arbitration from reset, both lanes continuously valid
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        L0_DATA = 64'h3F80_0000; L0_IS_DOUBLE = 1'b1; L0_RM = 3'b000;
        L1_DATA = 64'h3F80_0000; L1_IS_DOUBLE = 1'b1; L1_RM = 3'b000;
        n0 = 0; n1 = 0;
        for (int cyc = 0; cyc < 40 && otag.size() < 4; cyc++) begin
            if (OUT_VALID) otag.push_back(OUT_TAG);
            L0_VALID = (glane.size() < 4);
            L1_VALID = (glane.size() < 4);
            L0_TAG = TAG_W'(10 + n0);
            L1_TAG = TAG_W'(20 + n1);
            #1;
            chk("arb_onehot", L0_READY && L1_READY, 64'd0);
            if (L0_READY && L0_VALID) begin
                glane.push_back(0); gtag.push_back(L0_TAG); n0++;
            end else if (L1_READY && L1_VALID) begin
                glane.push_back(1); gtag.push_back(L1_TAG); n1++;
            end
            @(posedge CLK); #1;
        end
        L0_VALID = 1'b0; L1_VALID = 1'b0;
        chk("arb_grant_count", glane.size(), 64'd4);
        chk("arb_grant0", (glane.size() > 0) ? glane[0] : 99, 64'd0);
        chk("arb_grant1", (glane.size() > 1) ? glane[1] : 99, 64'd1);
        chk("arb_grant2", (glane.size() > 2) ? glane[2] : 99, 64'd0);
        chk("arb_grant3", (glane.size() > 3) ? glane[3] : 99, 64'd1);
        chk("arb_out0", (otag.size() > 0) ? otag[0] : 6'h3F, 64'd10);
        chk("arb_out1", (otag.size() > 1) ? otag[1] : 6'h3F, 64'd20);
        chk("arb_out2", (otag.size() > 2) ? otag[2] : 6'h3F, 64'd11);
        chk("arb_out3", (otag.size() > 3) ? otag[3] : 6'h3F, 64'd21);
        chk("arb_idle", BUSY, 64'd0);

        // Backpressure: only DEPTH uops fit, then drain in order
        glane.delete(); gtag.delete(); otag.delete();
        n0 = 0; n1 = 0;
        OUT_READY = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            L0_VALID = 1'b1; L1_VALID = 1'b1;
            L0_TAG = TAG_W'(30 + n0);
            L1_TAG = TAG_W'(40 + n1);
            #1;
            if (L0_READY) begin
                glane.push_back(0); gtag.push_back(L0_TAG); n0++;
            end else if (L1_READY) begin
                glane.push_back(1); gtag.push_back(L1_TAG); n1++;
            end
            @(posedge CLK); #1;
        end
        chk("bp_accepted", glane.size(), DEPTH);
        chk("bp_l0_ready_low", L0_READY, 64'd0);
        chk("bp_l1_ready_low", L1_READY, 64'd0);
        chk("bp_first_lane", (glane.size() > 0) ? glane[0] : 99, 64'd0);
        chk("bp_second_lane", (glane.size() > 1) ? glane[1] : 99, 64'd1);
        L0_VALID = 1'b0; L1_VALID = 1'b0;
        OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (OUT_VALID) otag.push_back(OUT_TAG);
            @(posedge CLK); #1;
        end
        chk("bp_drained", otag.size(), DEPTH);
        chk("bp_out0", (otag.size() > 0) ? otag[0] : 6'h3F, 64'd30);
        chk("bp_out1", (otag.size() > 1) ? otag[1] : 6'h3F, 64'd40);
        chk("bp_idle", BUSY, 64'd0);

        // Flush with one entry buffered and one in S1
        OUT_READY = 1'b0;
        L0_VALID = 1'b1; L0_TAG = 6'd50;
        #1;
        chk("fl_acc_a", L0_READY, 64'd1);
        @(posedge CLK); #1;
        L0_TAG = 6'd51;
        #1;
        chk("fl_acc_b", L0_READY, 64'd1);
        @(posedge CLK); #1;
        chk("fl_pre_busy", BUSY, 64'd1);
        chk("fl_pre_valid", OUT_VALID, 64'd1);
        L0_TAG = 6'd52;
        FLUSH = 1'b1;
        #1;
        chk("fl_no_accept", L0_READY, 64'd0);
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        chk("fl_out_valid", OUT_VALID, 64'd0);
        chk("fl_busy", BUSY, 64'd0);
        #1;
        chk("fl_post_ready", L0_READY, 64'd1);
        @(posedge CLK); #1;
        L0_VALID = 1'b0;
        OUT_READY = 1'b1;
        chk("fl_post_lat", OUT_VALID, 64'd0);
        @(posedge CLK); #1;
        chk("fl_post_valid", OUT_VALID, 64'd1);
        chk("fl_post_tag", OUT_TAG, 64'd52);
        @(posedge CLK); #1;
        chk("fl_post_empty", OUT_VALID, 64'd0);

        // Reset in the middle of traffic
        OUT_READY = 1'b0;
        L1_VALID = 1'b1; L1_TAG = 6'd60;
        @(posedge CLK); #1;
        L1_VALID = 1'b0;
        @(posedge CLK); #1;
        chk("rst_mid_busy_before", BUSY, 64'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("rst_mid_busy", BUSY, 64'd0);
        chk("rst_mid_valid", OUT_VALID, 64'd0);
        OUT_READY = 1'b1;
        issue_one(1, 64'h3FF0_0000_0000_0000, 3'b000, 1'b0, 6'd61,
                  64'hFFFF_FFFF_3F80_0000, 5'b00000, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
